// File: rtl/game_ctrl_fsm_if.sv
// Handshake bundle between the game controller and the board datapath.
// master = controller side, slave = movement/spawn/checker side.
interface game_ctrl_fsm_if #(
  parameter int unsigned NUM_DIRS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic [NUM_DIRS-1:0] btn;
  logic                game_over;
  logic                game_won;
  logic                move_ack;
  logic                move_changed;
  logic                spawn_ack;
  logic                board_clr;
  logic                move_req;
  logic [NUM_DIRS-1:0] move_dir;
  logic                spawn_req;
  logic [2:0]          state_o;
  logic [CNT_W-1:0]    move_count;
  logic                fault;

  modport master (
    input  btn, game_over, game_won, move_ack, move_changed, spawn_ack,
    output board_clr, move_req, move_dir, spawn_req, state_o, move_count, fault
  );

  modport slave (
    output btn, game_over, game_won, move_ack, move_changed, spawn_ack,
    input  board_clr, move_req, move_dir, spawn_req, state_o, move_count, fault
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Tile-game sequencing controller: registered FSM issuing move/spawn handshakes.
// Optional GAME_CTRL_AUTO_RESTART_EN: WIN/LOSE restart after HOLD_CYCLES instead of on a press.
module game_ctrl_fsm #(
  parameter int unsigned NUM_DIRS    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned INIT_SPAWNS = 2
) (
  input logic             clk,
  input logic             rst,
  game_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    StClear = 3'd0,
    StInit  = 3'd1,
    StIdle  = 3'd2,
    StMove  = 3'd3,
    StSpawn = 3'd4,
    StCheck = 3'd5,
    StWin   = 3'd6,
    StLose  = 3'd7
  } state_e;

  localparam int unsigned WaitW  = $clog2(ACK_TIMEOUT);
  localparam int unsigned SpawnW = $clog2(INIT_SPAWNS + 1);
  localparam logic [WaitW-1:0]  WaitMax   = WaitW'(ACK_TIMEOUT - 1);
  localparam logic [SpawnW-1:0] SpawnLast = SpawnW'(INIT_SPAWNS - 1);

  if (ACK_TIMEOUT < 2 || HOLD_CYCLES < 1 || INIT_SPAWNS < 1) begin : g_bad_params
    $error("game_ctrl_fsm: illegal parameter value");
  end

  state_e              state_q, state_d;
  logic [NUM_DIRS-1:0] btn_q, rise;
  logic                rise_one;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [SpawnW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0]    move_count_q, move_count_d;
  logic [NUM_DIRS-1:0] move_dir_q, move_dir_d;
  logic                board_clr_q, board_clr_d;
  logic                move_req_q, move_req_d;
  logic                spawn_req_q, spawn_req_d;
  logic                fault_q, fault_d;
  logic                timeout, spawn_gap;

`ifdef GAME_CTRL_AUTO_RESTART_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
  logic [HoldW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  always_comb begin
    rise     = bus.btn & ~btn_q;
    rise_one = (rise != '0) && ((rise & (rise - NUM_DIRS'(1))) == '0);

    state_d      = state_q;
    wait_d       = '0;
    spawn_cnt_d  = spawn_cnt_q;
    move_count_d = move_count_q;
    timeout      = 1'b0;
    spawn_gap    = 1'b0;
`ifdef GAME_CTRL_AUTO_RESTART_EN
    hold_d       = '0;
`endif

    case (state_q)
      StClear: begin
        spawn_cnt_d = '0;
        state_d     = StInit;
      end
      StInit: begin
        // An ack seen while the request is in its one-cycle gap is stray.
        if (spawn_req_q && bus.spawn_ack) begin
          spawn_gap   = 1'b1;
          spawn_cnt_d = spawn_cnt_q + SpawnW'(1);
          if (spawn_cnt_q == SpawnLast) state_d = StIdle;
        end else if (wait_q == WaitMax) begin
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StIdle: begin
        if (bus.game_won)       state_d = StWin;
        else if (bus.game_over) state_d = StLose;
        else if (rise_one)      state_d = StMove;
      end
      StMove: begin
        if (bus.move_ack) begin
          if (bus.move_changed) begin
            if (move_count_q != '1) move_count_d = move_count_q + CNT_W'(1);
            state_d = StSpawn;
          end else begin
            state_d = StIdle;
          end
        end else if (wait_q == WaitMax) begin
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StSpawn: begin
        if (bus.spawn_ack)           state_d = StCheck;
        else if (wait_q == WaitMax)  timeout = 1'b1;
        else                         wait_d  = wait_q + WaitW'(1);
      end
      StCheck: begin
        if (bus.game_won)       state_d = StWin;
        else if (bus.game_over) state_d = StLose;
        else                    state_d = StIdle;
      end
      StWin, StLose: begin
`ifdef GAME_CTRL_AUTO_RESTART_EN
        if (hold_q == HoldMax) state_d = StClear;
        else                   hold_d  = hold_q + HoldW'(1);
`else
        if (rise != '0) state_d = StClear;
`endif
      end
      default: state_d = StClear;
    endcase

    if (timeout) state_d = StClear;
    if (state_d == StClear) move_count_d = '0;

    // Outputs are registered, so they are decoded from the upcoming state.
    board_clr_d = (state_q == StClear);
    move_req_d  = (state_d == StMove);
    spawn_req_d = (state_d == StSpawn) || ((state_d == StInit) && !spawn_gap);
    move_dir_d  = (state_d != StMove) ? '0 : (state_q == StIdle) ? rise : move_dir_q;
    fault_d     = fault_q | timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StClear;
      btn_q        <= '0;
      wait_q       <= '0;
      spawn_cnt_q  <= '0;
      move_count_q <= '0;
      move_dir_q   <= '0;
      board_clr_q  <= 1'b0;
      move_req_q   <= 1'b0;
      spawn_req_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_q        <= bus.btn;
      wait_q       <= wait_d;
      spawn_cnt_q  <= spawn_cnt_d;
      move_count_q <= move_count_d;
      move_dir_q   <= move_dir_d;
      board_clr_q  <= board_clr_d;
      move_req_q   <= move_req_d;
      spawn_req_q  <= spawn_req_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.board_clr  = board_clr_q;
  assign bus.move_req   = move_req_q;
  assign bus.move_dir   = move_dir_q;
  assign bus.spawn_req  = spawn_req_q;
  assign bus.state_o    = state_q;
  assign bus.move_count = move_count_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm (NUM_DIRS=4, ACK_TIMEOUT=8, HOLD_CYCLES=4, INIT_SPAWNS=2).
// Covers both GAME_CTRL_AUTO_RESTART_EN builds in the WIN restart step.
module tb_game_ctrl_fsm;

  localparam logic [2:0] SClear = 3'd0, SInit = 3'd1, SIdle = 3'd2, SMove = 3'd3;
  localparam logic [2:0] SSpawn = 3'd4, SCheck = 3'd5, SWin = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  game_ctrl_fsm_if #(.NUM_DIRS(4), .CNT_W(16)) bus ();

  game_ctrl_fsm #(
    .NUM_DIRS(4), .CNT_W(16), .ACK_TIMEOUT(8), .HOLD_CYCLES(4), .INIT_SPAWNS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One INIT/SPAWN acknowledge round, waiting a bounded time for the request.
  task automatic spawn_round(input string tag);
    int n = 0;
    while (bus.spawn_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'd0, bus.spawn_req}, 32'd1);
    bus.spawn_ack = 1'b1;
    step();
    bus.spawn_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, bus.spawn_req}, 32'd0);
  endtask

  initial begin
    bus.btn = 4'b0000;
    bus.game_over = 1'b0;
    bus.game_won = 1'b0;
    bus.move_ack = 1'b0;
    bus.move_changed = 1'b0;
    bus.spawn_ack = 1'b0;

    #2;
    chk("rst_state", {29'd0, bus.state_o}, SClear);
    chk("rst_outputs", {bus.board_clr, bus.move_req, bus.spawn_req, bus.fault, bus.move_dir}, 0);
    chk("rst_count", {16'd0, bus.move_count}, 0);
    step();
    step();
    rst = 1'b0;

    // Start-up: one clear pulse then two spawn rounds.
    step();
    chk("init_state", {29'd0, bus.state_o}, SInit);
    chk("init_clr", {31'd0, bus.board_clr}, 1);
    spawn_round("init0");
    chk("clr_single", {31'd0, bus.board_clr}, 0);
    spawn_round("init1");
    chk("idle_state", {29'd0, bus.state_o}, SIdle);
    chk("idle_count", {16'd0, bus.move_count}, 0);
    chk("idle_fault", {31'd0, bus.fault}, 0);

    // Single press, ack after three cycles with a board change.
    bus.btn = 4'b0100;
    step();
    chk("mv_state", {29'd0, bus.state_o}, SMove);
    for (int i = 0; i < 3; i++) begin
      chk("mv_req", {31'd0, bus.move_req}, 1);
      chk("mv_dir", {28'd0, bus.move_dir}, 32'h4);
      if (i == 2) begin
        bus.move_ack = 1'b1;
        bus.move_changed = 1'b1;
      end
      step();
    end
    bus.move_ack = 1'b0;
    bus.move_changed = 1'b0;
    bus.btn = 4'b0000;
    chk("sp_state", {29'd0, bus.state_o}, SSpawn);
    chk("sp_req_drop", {31'd0, bus.move_req}, 0);
    chk("sp_dir_clr", {28'd0, bus.move_dir}, 0);
    chk("sp_count", {16'd0, bus.move_count}, 1);
    spawn_round("move_spawn");
    chk("chk_state", {29'd0, bus.state_o}, SCheck);
    step();
    chk("back_idle", {29'd0, bus.state_o}, SIdle);

    // Two simultaneous edges are discarded; a stray ack in IDLE is ignored.
    bus.btn = 4'b0011;
    step();
    chk("multi_state", {29'd0, bus.state_o}, SIdle);
    chk("multi_req", {31'd0, bus.move_req}, 0);
    bus.move_ack = 1'b1;
    bus.move_changed = 1'b1;
    step();
    bus.move_ack = 1'b0;
    bus.move_changed = 1'b0;
    chk("stray_state", {29'd0, bus.state_o}, SIdle);
    chk("stray_count", {16'd0, bus.move_count}, 1);
    chk("stray_spawn", {31'd0, bus.spawn_req}, 0);

    // Move acknowledged without a board change: no spawn, no count.
    bus.btn = 4'b0000;
    step();
    bus.btn = 4'b0001;
    step();
    chk("nochg_dir", {28'd0, bus.move_dir}, 32'h1);
    bus.move_ack = 1'b1;
    step();
    bus.move_ack = 1'b0;
    chk("nochg_state", {29'd0, bus.state_o}, SIdle);
    chk("nochg_spawn", {31'd0, bus.spawn_req}, 0);
    chk("nochg_count", {16'd0, bus.move_count}, 1);

    // Move never acknowledged: eight request cycles, then fault and restart.
    bus.btn = 4'b0000;
    step();
    bus.btn = 4'b1000;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("to_req_held", {31'd0, bus.move_req}, 1);
      chk("to_no_fault", {31'd0, bus.fault}, 0);
      step();
    end
    chk("to_state", {29'd0, bus.state_o}, SClear);
    chk("to_fault", {31'd0, bus.fault}, 1);
    chk("to_req", {31'd0, bus.move_req}, 0);
    chk("to_count", {16'd0, bus.move_count}, 0);
    step();
    chk("to_init", {29'd0, bus.state_o}, SInit);
    chk("to_clr", {31'd0, bus.board_clr}, 1);
    spawn_round("re0");
    spawn_round("re1");
    chk("re_idle", {29'd0, bus.state_o}, SIdle);
    chk("fault_sticky", {31'd0, bus.fault}, 1);

    // Move, spawn, then CHECK sees both won and over: WIN has priority.
    bus.btn = 4'b0000;
    step();
    bus.btn = 4'b0010;
    step();
    bus.move_ack = 1'b1;
    bus.move_changed = 1'b1;
    step();
    bus.move_ack = 1'b0;
    bus.move_changed = 1'b0;
    bus.game_won = 1'b1;
    bus.game_over = 1'b1;
    bus.spawn_ack = 1'b1;
    step();
    bus.spawn_ack = 1'b0;
    chk("win_check", {29'd0, bus.state_o}, SCheck);
    step();
    chk("win_state", {29'd0, bus.state_o}, SWin);
    bus.game_won = 1'b0;
    bus.game_over = 1'b0;
    bus.btn = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("win_hold", {29'd0, bus.state_o}, SWin);
      chk("win_no_move", {31'd0, bus.move_req}, 0);
    end
`ifdef GAME_CTRL_AUTO_RESTART_EN
    step();
`else
    step();
    chk("win_wait_press", {29'd0, bus.state_o}, SWin);
    bus.btn = 4'b0101;
    step();
`endif
    chk("win_restart", {29'd0, bus.state_o}, SClear);
    bus.btn = 4'b0000;
    step();
    spawn_round("w0");
    spawn_round("w1");

    // Reset asserted mid-spawn drops the request without a clock edge.
    step();
    bus.btn = 4'b0100;
    step();
    bus.move_ack = 1'b1;
    bus.move_changed = 1'b1;
    step();
    bus.move_ack = 1'b0;
    bus.move_changed = 1'b0;
    chk("pre_rst_spawn", {31'd0, bus.spawn_req}, 1);
    chk("pre_rst_count", {16'd0, bus.move_count}, 1);
    rst = 1'b1;
    #1;
    chk("arst_spawn", {31'd0, bus.spawn_req}, 0);
    chk("arst_state", {29'd0, bus.state_o}, SClear);
    chk("arst_count", {16'd0, bus.move_count}, 0);
    chk("arst_fault", {31'd0, bus.fault}, 0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised sequencing controller for the tile-game top level.
- Turns debounced direction buttons into single, handshaked move commands to the movement unit, then spawn requests to the random-tile generator.
- Tracks win/lose, counts moves, recovers from a stalled handshake, and restarts the game after an end state.
- Replaces the free-running combinational next-state logic with a fully registered FSM with request/acknowledge handshakes.

Parameters:
- NUM_DIRS, 4, number of direction buttons; width of btn and move_dir.
- CNT_W, 16, move_count width.
- ACK_TIMEOUT, 1024, cycles allowed for move_ack/spawn_ack before fault; must be >=2.
- HOLD_CYCLES, 50000000, WIN/LOSE display time before auto-restart (AUTO_RESTART_EN only); must be >=1.
- INIT_SPAWNS, 2, tiles spawned at game start; must be >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- btn  in  NUM_DIRS  debounced button levels, synchronous to clk.
- game_over  in  1  no legal move remains (from game-state checker).
- game_won  in  1  winning tile present.
- move_ack  in  1  one-cycle pulse, movement unit finished.
- move_changed  in  1  valid with move_ack; board changed.
- spawn_ack  in  1  one-cycle pulse, tile placed.
- board_clr  out  1  one-cycle board clear pulse.
- move_req  out  1  move request level.
- move_dir  out  NUM_DIRS  one-hot direction, stable while move_req=1.
- spawn_req  out  1  spawn request level.
- state_o  out  3  current state encoding.
- move_count  out  CNT_W  accepted board-changing moves.
- fault  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=CLEAR, all outputs 0, edge register and counters 0.
- Encoding: CLEAR=0, INIT=1, IDLE=2, MOVE=3, SPAWN=4, CHECK=5, WIN=6, LOSE=7. All outputs are registered and decoded from state.
- Edge detection: btn_q is the previous btn. rise = btn & ~btn_q. btn_q updates every cycle in every state.
- CLEAR:
  - board_clr=1 for exactly one cycle.
  - move_count cleared; spawn counter cleared.
  - Next state: INIT.
- INIT:
  - spawn_req=1 until spawn_ack.
  - Each ack increments the spawn counter and drops spawn_req for one cycle.
  - After INIT_SPAWNS acks: IDLE.
- IDLE, checked in priority order:
  - game_won -> WIN.
  - game_over -> LOSE.
  - Exactly one bit of rise set -> latch move_dir=rise, go MOVE.
  - Zero or more than one rising edge -> stay; the event is discarded, not queued.
- MOVE:
  - move_req=1 from the entry cycle until the cycle move_ack is sampled. move_req drops on the next cycle.
  - On ack with move_changed=1: move_count++ (saturates at all-ones), go SPAWN.
  - On ack with move_changed=0: go IDLE. No spawn, no count.
  - move_dir clears on exit.
- SPAWN: spawn_req=1 until spawn_ack, then CHECK.
- CHECK: one settle cycle, then:
  - game_won -> WIN.
  - else game_over -> LOSE.
  - else IDLE.
- Timeout:
  - A wait counter runs in INIT, MOVE and SPAWN; it resets on each ack and on state entry.
  - At ACK_TIMEOUT cycles without ack: fault<=1, drop all requests, go CLEAR.
  - fault clears only on rst.
- Stray acks: acks outside the matching wait state are ignored.
- WIN/LOSE: direction presses do not generate moves; restart behaviour is set by the optional feature.
- Reset mid-handshake: requests drop asynchronously. The peer must tolerate an abandoned request.

Optional Feature:
- Macro: GAME_CTRL_AUTO_RESTART_EN.
- Defined: WIN/LOSE count HOLD_CYCLES cycles, then go to CLEAR. Button edges are ignored while counting.
- Undefined: WIN/LOSE hold indefinitely. Any single or multiple rising edge on btn goes to CLEAR the next cycle. The hold counter is not synthesised.

Test Plan (NUM_DIRS=4, ACK_TIMEOUT=8, HOLD_CYCLES=4, INIT_SPAWNS=2):
- Release rst -> board_clr one pulse; two spawn_req/spawn_ack rounds; state_o=2; move_count=0; fault=0.
- IDLE, btn 0000->0100, move_ack+move_changed=1 after 3 cycles -> move_dir=0100 throughout; one spawn round; CHECK; IDLE; move_count=1.
- btn 0000->0011 same cycle -> stays IDLE, move_req never asserts. Then move_ack with move_changed=0 -> no spawn_req, move_count unchanged.
- MOVE with no move_ack for 8 cycles -> fault=1, move_req=0, CLEAR then INIT. fault stays 1 until rst.
- CHECK with game_won=1 and game_over=1 -> WIN. With macro: CLEAR after 4 cycles. Without macro: remains WIN until a btn rising edge, then CLEAR.
- Assert rst during SPAWN with spawn_req=1 -> spawn_req=0 immediately; state_o=0; move_count=0.
